// File: rtl/signed_divider.sv
// signed_divider: 16-bit two's complement restoring divider, fixed 18-cycle latency.
module signed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] Q,
  input  logic [15:0] M,
  output logic [15:0] Quo,
  output logic [15:0] Rem,
  output logic        DVF,
  output logic        ZE,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;
  state_t state_q, state_d;
  logic [15:0] qi_q, qi_d, mi_q, mi_d, qb_q, qb_d, mm_q, mm_d;
  logic [15:0] quo_q, quo_d, rem_q, rem_d, qfix, rfix;
  logic [16:0] a_q, a_d, sh, diff;
  logic [3:0]  cnt_q, cnt_d;
  logic        sq_q, sq_d, sm_q, sm_d, dvf_q, dvf_d, ze_q, ze_d;
  logic        busy_q, busy_d, done_q, done_d, zero;
  always_comb begin
    state_d = state_q;
    qi_d    = qi_q;
    mi_d    = mi_q;
    qb_d    = qb_q;
    mm_d    = mm_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sm_d    = sm_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvf_d   = dvf_q;
    ze_d    = ze_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sh      = {a_q[15:0], qb_q[15]};
    diff    = sh - {1'b0, mm_q};
    qfix    = (sq_q ^ sm_q) ? -qb_q : qb_q;
    rfix    = sq_q ? -a_q[15:0] : a_q[15:0];
    zero    = mi_q == 16'h0000;
    case (state_q)
      IDLE: if (start) begin
        qi_d    = Q;
        mi_d    = M;
        busy_d  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        sq_d    = qi_q[15];
        sm_d    = mi_q[15];
        qb_d    = qi_q[15] ? -qi_q : qi_q;
        mm_d    = mi_q[15] ? -mi_q : mi_q;
        a_d     = '0;
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        a_d     = diff[16] ? sh : diff;
        qb_d    = {qb_q[14:0], ~diff[16]};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd15) ? FIX : ITER;
      end
      FIX: begin
        // Zero divisor still runs the full iteration so latency never depends on operands.
        quo_d   = zero ? 16'h0000 : qfix;
        rem_d   = zero ? qi_q : rfix;
        ze_d    = zero;
        dvf_d   = zero | (qi_q == 16'h8000 && mi_q == 16'hFFFF);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      qi_q    <= '0;
      mi_q    <= '0;
      qb_q    <= '0;
      mm_q    <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sm_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvf_q   <= 1'b0;
      ze_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qi_q    <= qi_d;
      mi_q    <= mi_d;
      qb_q    <= qb_d;
      mm_q    <= mm_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sm_q    <= sm_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvf_q   <= dvf_d;
      ze_q    <= ze_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign Quo  = quo_q;
  assign Rem  = rem_q;
  assign DVF  = dvf_q;
  assign ZE   = ze_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: random and directed checks of signed_divider against plain integer division.
module tb_signed_divider;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] Q, M, Quo, Rem;
  logic        DVF, ZE, busy, done;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  signed_divider dut (
    .clk(clk), .rst(rst), .start(start), .Q(Q), .M(M),
    .Quo(Quo), .Rem(Rem), .DVF(DVF), .ZE(ZE), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic run_div(input logic [15:0] q, input logic [15:0] m, input int poke);
    int qs, ms, eq, er, gq, gr, n;
    logic edvf, eze;
    qs = int'($signed(q));
    ms = int'($signed(m));
    if (ms == 0) begin
      eq = 0; er = qs; edvf = 1'b1; eze = 1'b1;
    end else if (qs == -32768 && ms == -1) begin
      eq = -32768; er = 0; edvf = 1'b1; eze = 1'b0;
    end else begin
      eq = qs / ms; er = qs % ms; edvf = 1'b0; eze = 1'b0;
    end
    @(negedge clk);
    Q = q; M = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; Q = 16'($urandom); M = 16'($urandom);
    check("busy_start", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      start = (n == poke);
      Q = 16'($urandom); M = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("latency", n, 32'd18);
    check("quo", 32'(Quo), 32'(eq[15:0]));
    check("rem", 32'(Rem), 32'(er[15:0]));
    check("dvf", 32'(DVF), 32'(edvf));
    check("ze", 32'(ZE), 32'(eze));
    check("busy_done", 32'(busy), 32'd0);
    if (!edvf) begin
      gq = int'($signed(Quo));
      gr = int'($signed(Rem));
      check("identity", 32'(qs - gq * ms - gr), 32'd0);
      check("rem_sign", 32'(Rem == 16'h0000 || Rem[15] == q[15]), 32'd1);
    end
    @(posedge clk); #1;
    check("hold_quo", 32'(Quo), 32'(eq[15:0]));
    check("done_pulse", 32'(done), 32'd0);
  endtask
  initial begin
    int seen;
    logic [15:0] rq, rm;
    rst = 1'b1; start = 1'b0; Q = '0; M = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quo", 32'(Quo), 32'd0);
    check("rst_rem", 32'(Rem), 32'd0);
    check("rst_flags", 32'({DVF, ZE, busy, done}), 32'd0);
    start = 1'b1; Q = 16'd5; M = 16'd1;
    @(posedge clk); #1;
    check("rst_over_start", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    run_div(16'd100, 16'd20, -1);
    run_div(-16'sd100, 16'd20, -1);
    run_div(16'd100, -16'sd20, -1);
    run_div(-16'sd100, -16'sd20, -1);
    run_div(16'd10, 16'd20, -1);
    run_div(-16'sd7, 16'd2, -1);
    run_div(16'd7, -16'sd2, -1);
    run_div(16'd0, 16'd20, -1);
    run_div(16'd12345, 16'd1, -1);
    run_div(16'd12345, 16'hFFFF, -1);
    run_div(16'd50, 16'd50, -1);
    run_div(16'd100, 16'd0, -1);
    run_div(16'h8000, 16'hFFFF, -1);
    run_div(16'd99, 16'd4, -1);
    run_div(16'h8000, 16'h8000, -1);
    run_div(16'h7FFF, 16'h8000, -1);
    run_div(16'd1000, 16'd7, 5);
    @(negedge clk);
    Q = 16'd100; M = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_quo", 32'(Quo), 32'd0);
    check("abort_rem", 32'(Rem), 32'd0);
    check("abort_flags", 32'({DVF, ZE, busy, done}), 32'd0);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    run_div(-16'sd300, 16'd7, -1);
    for (int i = 0; i < 300; i++) begin
      rq = 16'($urandom);
      rm = 16'($urandom);
      case ($urandom_range(0, 9))
        0: rm = 16'h0000;
        1: begin rq = 16'h8000; rm = 16'hFFFF; end
        2: rm = 16'($signed(5'($urandom)));
        3: rq = 16'h8000;
        default: ;
      endcase
      run_div(rq, rm, (i % 17 == 0) ? int'($urandom_range(0, 16)) : -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
